ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 104 ++++++++++
 tb/tb_ram_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port data RAM with async read data.
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise m0 has fixed priority.
module ram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  input  logic [31:0] ram_dout
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic        acc_we;
  logic        acc_id;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        pick1;
  logic        grant;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  logic last_id;

  // On a tie, m1 wins only when m0 was the last port granted.
  assign pick1 = m1_req & (~m0_req | ~last_id);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_id <= 1'b1;
    end else if (grant) begin
      last_id <= pick1;
    end
  end
`else
  assign pick1 = m1_req & ~m0_req;
`endif

  // NOTE: gnt is combinational, so it is gated by reset to stay low while reset is held.
  assign grant  = reset & (state == IDLE) & (m0_req | m1_req);
  assign m0_gnt = grant & ~pick1;
  assign m1_gnt = grant & pick1;

  assign ram_addr = acc_addr;
  assign ram_din  = acc_wdata;
  assign ram_we   = (state == ACCESS) & acc_we;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc_we    <= 1'b0;
      acc_id    <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            acc_id    <= pick1;
            acc_we    <= pick1 ? m1_we    : m0_we;
            acc_addr  <= pick1 ? m1_addr  : m0_addr;
            acc_wdata <= pick1 ? m1_wdata : m0_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!acc_we) begin
            if (acc_id) begin
              m1_rvalid <= 1'b1;
              m1_rdata  <= ram_dout;
            end else begin
              m0_rvalid <= 1'b1;
              m0_rdata  <= ram_dout;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a small behavioural RAM model.
// Follows RAM_ARBITER_ROUND_ROBIN_EN to pick the expected contested-grant order.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] ram_addr, ram_din, ram_dout;
  logic        ram_we;

  logic [31:0] mem [0:255];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  assign ram_dout = mem[ram_addr[7:0]];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_din;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    #2;
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_m1_rdata", m1_rdata, 0);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);

    @(negedge clk); reset = 1'b1; m0_req = 1'b0;

    // m0 write 0x10 <- 0xDEADBEEF
    @(negedge clk); m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    #1 check("wr0_gnt", {m0_gnt, m1_gnt}, 2'b10);
    check("wr0_we_idle", ram_we, 0);
    @(negedge clk); m0_req = 1'b0;
    #1 check("wr0_gnt_access", m0_gnt, 0);
    check("wr0_ram_we", ram_we, 1);
    check("wr0_ram_addr", ram_addr, 32'h10);
    check("wr0_ram_din", ram_din, 32'hDEADBEEF);
    @(negedge clk);
    #1 check("wr0_we_after", ram_we, 0);
    check("wr0_no_rvalid", m0_rvalid, 0);
    check("wr0_addr_hold", ram_addr, 32'h10);

    // m0 read 0x10
    @(negedge clk); m0_req = 1'b1; m0_we = 1'b0;
    #1 check("rd0_gnt", {m0_gnt, m1_gnt}, 2'b10);
    @(negedge clk); m0_req = 1'b0;
    #1 check("rd0_we_access", ram_we, 0);
    check("rd0_rvalid_n1", m0_rvalid, 0);
    @(negedge clk);
    #1 check("rd0_rvalid_n2", m0_rvalid, 1);
    check("rd0_rdata", m0_rdata, 32'hDEADBEEF);
    @(negedge clk);
    #1 check("rd0_rvalid_n3", m0_rvalid, 0);
    check("rd0_rdata_hold", m0_rdata, 32'hDEADBEEF);

    // m1 write/read at a full-width address
    @(negedge clk); m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hFFFFFF20; m1_wdata = 32'h12345678;
    #1 check("wr1_gnt", {m0_gnt, m1_gnt}, 2'b01);
    @(negedge clk); m1_req = 1'b0;
    #1 check("wr1_ram_we", ram_we, 1);
    check("wr1_ram_addr", ram_addr, 32'hFFFFFF20);
    check("wr1_ram_din", ram_din, 32'h12345678);
    @(negedge clk);
    #1 check("wr1_no_rvalid", {ram_we, m1_rvalid}, 0);
    m1_req = 1'b1; m1_we = 1'b0;
    #1 check("rd1_gnt", {m0_gnt, m1_gnt}, 2'b01);
    @(negedge clk); m1_req = 1'b0;
    @(negedge clk);
    #1 check("rd1_rvalid", {m0_rvalid, m1_rvalid}, 2'b01);
    check("rd1_rdata", m1_rdata, 32'h12345678);
    check("rd1_m0_rdata_hold", m0_rdata, 32'hDEADBEEF);

    // m1 pulses req only while m0's access is in progress
    @(negedge clk); m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
    #1 check("drop_m0_gnt", m0_gnt, 1);
    @(negedge clk); m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h99; m1_wdata = 32'h55;
    #1 check("drop_m1_gnt_access", m1_gnt, 0);
    @(negedge clk); m1_req = 1'b0;
    #1 check("drop_m1_gnt_idle", {m1_gnt, ram_we}, 0);
    check("drop_m0_rdata", {m0_rvalid, m0_rdata}, {1'b1, 32'h12345678});
    @(negedge clk);
    #1 check("drop_no_activity", {ram_we, m1_rvalid}, 0);
    check("drop_addr_hold", ram_addr, 32'h20);

    // reset in the middle of an m1 write
    @(negedge clk); m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_wdata = 32'hCAFEF00D;
    #1 check("abort_gnt", m1_gnt, 1);
    @(negedge clk); m1_req = 1'b0;
    #1 check("abort_we_before", ram_we, 1);
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hFFFFFF20;
    #1 check("abort_ram_we", ram_we, 0);
    check("abort_ram_addr", ram_addr, 0);
    check("abort_ram_din", ram_din, 0);
    check("abort_rdata", {m0_rdata, m1_rdata}, 0);
    check("abort_gnt_in_reset", {m0_gnt, m1_gnt}, 0);
    @(negedge clk);
    check("abort_mem_untouched", mem[8'h40], 0);

    // both masters requesting continuously from reset release
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] exp_gnt;
      if (i > 0) @(negedge clk);
      #1;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      exp_gnt = (i % 2 != 0) ? 2'b00 : ((i % 4 == 0) ? 2'b10 : 2'b01);
`else
      exp_gnt = (i % 2 != 0) ? 2'b00 : 2'b10;
`endif
      check($sformatf("contest_gnt_c%0d", i), {m0_gnt, m1_gnt}, exp_gnt);
      if (i < 2) check($sformatf("contest_no_m1_rvalid_c%0d", i), m1_rvalid, 0);
      if (i == 2) check("contest_m0_rdata", {m0_rvalid, m0_rdata}, {1'b1, 32'hDEADBEEF});
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
